booth_mul_arbiter: RTL

BOOTH_MUL_ARBITER -- requirements
Module: booth_mul_arbiter

---
 rtl/booth_mul_arbiter.sv | 116 +++++++++++
 1 files changed

// File: rtl/booth_mul_arbiter.sv
// Two-channel round-robin front end for a shared sequential Booth multiplier core.
// Grants one request at a time, issues it to the core, waits for completion with a
// 6-bit watchdog, and holds the response until the consumer accepts it.
module booth_mul_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req_valid,
    input  logic [15:0] req_a0,
    input  logic [15:0] req_b0,
    input  logic [15:0] req_a1,
    input  logic [15:0] req_b1,
    output logic [1:0]  req_ready,
    output logic        mul_start,
    output logic [15:0] mul_a,
    output logic [15:0] mul_b,
    input  logic        mul_done,
    input  logic [31:0] mul_result,
    output logic        rsp_valid,
    output logic        rsp_id,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    input  logic        rsp_ready
);

    typedef enum logic [1:0] {StIdle, StIssue, StBusy, StResp} state_t;

    // Watchdog value seen in the last BUSY cycle before the count reaches 63.
    localparam logic [5:0] WdogLast = 6'd62;

    state_t     state;
    logic       last_grant;
    logic       cur_id;
    logic [5:0] wdog;
    logic [1:0] grant;
    logic       grant_id;

    // Round-robin pick: a lone requester always wins, a tie goes away from last_grant.
    always_comb begin
        grant    = 2'b00;
        grant_id = 1'b0;
        if (req_valid == 2'b11) begin
            grant_id = ~last_grant;
            grant    = grant_id ? 2'b10 : 2'b01;
        end else if (req_valid[0]) begin
            grant    = 2'b01;
            grant_id = 1'b0;
        end else if (req_valid[1]) begin
            grant    = 2'b10;
            grant_id = 1'b1;
        end
    end

    // The accept strobe is only offered in IDLE so the request is consumed on the
    // same edge that latches its operands; it is suppressed while reset is held.
    assign req_ready = (state == StIdle && !rst) ? grant : 2'b00;

    // Main FSM with registered core and response outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= StIdle;
            last_grant <= 1'b1;
            cur_id     <= 1'b0;
            wdog       <= 6'd0;
            mul_start  <= 1'b0;
            mul_a      <= 16'd0;
            mul_b      <= 16'd0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_data   <= 32'd0;
            rsp_err    <= 1'b0;
        end else begin
            mul_start <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (grant != 2'b00) begin
                        last_grant <= grant_id;
                        cur_id     <= grant_id;
                        mul_a      <= grant_id ? req_a1 : req_a0;
                        mul_b      <= grant_id ? req_b1 : req_b0;
                        mul_start  <= 1'b1;
                        state      <= StIssue;
                    end
                end
                StIssue: begin
                    wdog  <= 6'd0;
                    state <= StBusy;
                end
                StBusy: begin
                    wdog <= wdog + 6'd1;
                    // wdog == 0 marks the first BUSY cycle, where done may be stale.
                    if (wdog != 6'd0 && mul_done) begin
                        rsp_data  <= mul_result;
                        rsp_err   <= 1'b0;
                        rsp_id    <= cur_id;
                        rsp_valid <= 1'b1;
                        state     <= StResp;
                    end else if (wdog == WdogLast) begin
                        rsp_data  <= 32'd0;
                        rsp_err   <= 1'b1;
                        rsp_id    <= cur_id;
                        rsp_valid <= 1'b1;
                        state     <= StResp;
                    end
                end
                StResp: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
